// File: rtl/bg_mem_pkg.sv
// Shared types and sizes for the background frame memory arbiter.
package bg_mem_pkg;

    localparam int ADDR_W = 19;
    localparam int DATA_W = 8;
    localparam int PIXELS = 307200;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_VGA  = 2'd1,
        OWN_HOST = 2'd2
    } owner_e;

    typedef enum logic [1:0] {
        FS_IDLE = 2'd0,
        FS_FILL = 2'd1,
        FS_DONE = 2'd2
    } fill_state_e;

    // zero marks a host read outside the frame: it was never issued and returns 0x00
    typedef struct packed {
        owner_e owner;
        logic   zero;
    } rd_tag_t;

endpackage

// File: rtl/bg_rd_return.sv
// Read-return path: tracks the owner of each issued read and steers mem_readdata
// back to that requester once the memory's fixed latency has elapsed.
module bg_rd_return
    import bg_mem_pkg::*;
#(
    parameter int READ_LATENCY = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  rd_tag_t           issue_tag,
    input  logic [DATA_W-1:0] mem_readdata,
    output logic              vga_rvalid,
    output logic [DATA_W-1:0] vga_rdata,
    output logic              host_rvalid,
    output logic [DATA_W-1:0] host_rdata
);

    rd_tag_t [READ_LATENCY:0] tag_q, tag_d;
    rd_tag_t                  ret_tag;
    logic [DATA_W-1:0]        ret_data;
    logic [DATA_W-1:0]        vga_rdata_q, vga_rdata_d;
    logic [DATA_W-1:0]        host_rdata_q, host_rdata_d;

    always_comb begin
        tag_d[0] = issue_tag;
        for (int i = 1; i <= READ_LATENCY; i++) begin
            tag_d[i] = tag_q[i-1];
        end
        ret_tag  = tag_q[READ_LATENCY];
        ret_data = ret_tag.zero ? '0 : mem_readdata;

        vga_rvalid   = (ret_tag.owner == OWN_VGA);
        host_rvalid  = (ret_tag.owner == OWN_HOST);
        vga_rdata_d  = vga_rvalid  ? ret_data : vga_rdata_q;
        host_rdata_d = host_rvalid ? ret_data : host_rdata_q;
        vga_rdata    = vga_rdata_d;
        host_rdata   = host_rdata_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_q        <= '0;
            vga_rdata_q  <= '0;
            host_rdata_q <= '0;
        end else begin
            tag_q        <= tag_d;
            vga_rdata_q  <= vga_rdata_d;
            host_rdata_q <= host_rdata_d;
        end
    end

endmodule

// File: rtl/bg_mem_arbiter.sv
// Arbitrates the background frame memory between VGA fetch, host port and the
// frame fill engine; VGA has priority, a starvation counter guarantees the others a slot.
module bg_mem_arbiter #(
    parameter int PIXELS       = bg_mem_pkg::PIXELS,
    parameter int READ_LATENCY = 1,
    parameter int MAX_WAIT     = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          vga_req,
    input  logic [bg_mem_pkg::ADDR_W-1:0] vga_addr,
    output logic                          vga_gnt,
    output logic                          vga_rvalid,
    output logic [bg_mem_pkg::DATA_W-1:0] vga_rdata,
    input  logic                          host_req,
    input  logic                          host_we,
    input  logic [bg_mem_pkg::ADDR_W-1:0] host_addr,
    input  logic [bg_mem_pkg::DATA_W-1:0] host_wdata,
    output logic                          host_gnt,
    output logic                          host_rvalid,
    output logic [bg_mem_pkg::DATA_W-1:0] host_rdata,
    input  logic                          fill_start,
    input  logic [bg_mem_pkg::DATA_W-1:0] fill_color,
    output logic                          fill_busy,
    output logic                          fill_done,
    output logic [bg_mem_pkg::ADDR_W-1:0] mem_address,
    output logic                          mem_chipselect,
    output logic                          mem_write,
    output logic [bg_mem_pkg::DATA_W-1:0] mem_writedata,
    output logic                          mem_clken,
    input  logic [bg_mem_pkg::DATA_W-1:0] mem_readdata
);

    import bg_mem_pkg::*;

    localparam int                SW        = $clog2(MAX_WAIT + 1);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(PIXELS - 1);
    localparam logic [SW-1:0]     WAIT_MAX  = SW'(MAX_WAIT);

    fill_state_e       state_q, state_d;
    logic [ADDR_W-1:0] fill_addr_q, fill_addr_d;
    logic [DATA_W-1:0] fill_color_q, fill_color_d;
    logic [SW-1:0]     starve_cnt_q, starve_cnt_d;
    logic [ADDR_W-1:0] mem_address_q, mem_address_d;
    logic              mem_cs_q, mem_cs_d;
    logic              mem_we_q, mem_we_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;

    logic    sec_req, sec_gnt, force_sec, host_in_range;
    rd_tag_t issue_tag;

    always_comb begin
        fill_busy     = (state_q != FS_IDLE);
        fill_done     = (state_q == FS_DONE);
        sec_req       = fill_busy ? (state_q == FS_FILL) : host_req;
        force_sec     = (starve_cnt_q == WAIT_MAX);
        sec_gnt       = sec_req && (!vga_req || force_sec);
        vga_gnt       = vga_req && !sec_gnt;
        host_gnt      = sec_gnt && !fill_busy;
        host_in_range = (host_addr <= LAST_ADDR);

        starve_cnt_d = starve_cnt_q;
        if (sec_gnt) begin
            starve_cnt_d = '0;
        end else if (sec_req && !force_sec) begin
            starve_cnt_d = starve_cnt_q + 1'b1;
        end
    end

    // Next memory access; address/data hold when idle to avoid needless toggling
    always_comb begin
        mem_cs_d      = 1'b0;
        mem_we_d      = 1'b0;
        mem_address_d = mem_address_q;
        mem_wdata_d   = mem_wdata_q;
        issue_tag     = '0;
        if (vga_gnt) begin
            mem_cs_d        = 1'b1;
            mem_address_d   = vga_addr;
            issue_tag.owner = OWN_VGA;
        end else if (host_gnt) begin
            if (host_in_range) begin
                mem_cs_d      = 1'b1;
                mem_we_d      = host_we;
                mem_address_d = host_addr;
                mem_wdata_d   = host_wdata;
            end
            if (!host_we) begin
                issue_tag.owner = OWN_HOST;
                issue_tag.zero  = !host_in_range;
            end
        end else if (sec_gnt) begin
            mem_cs_d      = 1'b1;
            mem_we_d      = 1'b1;
            mem_address_d = fill_addr_q;
            mem_wdata_d   = fill_color_q;
        end
    end

    always_comb begin
        state_d      = state_q;
        fill_addr_d  = fill_addr_q;
        fill_color_d = fill_color_q;
        case (state_q)
            FS_IDLE: begin
                if (fill_start) begin
                    fill_color_d = fill_color;
                    fill_addr_d  = '0;
                    state_d      = FS_FILL;
                end
            end
            FS_FILL: begin
                if (sec_gnt) begin
                    fill_addr_d = fill_addr_q + 1'b1;
                    if (fill_addr_q == LAST_ADDR) begin
                        state_d = FS_DONE;
                    end
                end
            end
            FS_DONE: state_d = FS_IDLE;
            default: state_d = FS_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= FS_IDLE;
            fill_addr_q   <= '0;
            fill_color_q  <= '0;
            starve_cnt_q  <= '0;
            mem_address_q <= '0;
            mem_cs_q      <= 1'b0;
            mem_we_q      <= 1'b0;
            mem_wdata_q   <= '0;
        end else begin
            state_q       <= state_d;
            fill_addr_q   <= fill_addr_d;
            fill_color_q  <= fill_color_d;
            starve_cnt_q  <= starve_cnt_d;
            mem_address_q <= mem_address_d;
            mem_cs_q      <= mem_cs_d;
            mem_we_q      <= mem_we_d;
            mem_wdata_q   <= mem_wdata_d;
        end
    end

    assign mem_address    = mem_address_q;
    assign mem_chipselect = mem_cs_q;
    assign mem_write      = mem_we_q;
    assign mem_writedata  = mem_wdata_q;
    assign mem_clken      = 1'b1;

    bg_rd_return #(
        .READ_LATENCY(READ_LATENCY)
    ) u_rd_return (
        .clk         (clk),
        .rst_n       (rst_n),
        .issue_tag   (issue_tag),
        .mem_readdata(mem_readdata),
        .vga_rvalid  (vga_rvalid),
        .vga_rdata   (vga_rdata),
        .host_rvalid (host_rvalid),
        .host_rdata  (host_rdata)
    );

endmodule

// File: doc/bg_mem_arbiter.md
Name: bg_mem_arbiter

Overview:
Shares the single-port 8-bit background frame memory (19-bit address, 640x480 pixels) between three requesters: the VGA pixel fetcher (highest priority), a host read/write port (game logic and loader), and an internal fill engine that clears the frame to one colour. It drives the memory's chipselect/write/address/writedata/clken slave signals and returns read data to the right requester after the memory's fixed read latency. A starvation counter guarantees the non-VGA side a slot.

Parameters:
ADDR_W, 19, memory address width
DATA_W, 8, pixel width
PIXELS, 307200, valid address range 0..PIXELS-1
READ_LATENCY, 1, cycles from memory request to valid mem_readdata (1 or 2)
MAX_WAIT, 8, consecutive denied cycles before the secondary side is forced a grant

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
vga_req  in  1  VGA read request; vga_addr held until vga_gnt
vga_addr  in  ADDR_W  VGA read address
vga_gnt  out  1  request accepted this cycle
vga_rvalid  out  1  vga_rdata valid, one pulse per grant
vga_rdata  out  DATA_W  read pixel
host_req  in  1  host request; host_we/host_addr/host_wdata held until host_gnt
host_we  in  1  1 = write, 0 = read
host_addr  in  ADDR_W  host address
host_wdata  in  DATA_W  host write data
host_gnt  out  1  host request accepted this cycle
host_rvalid  out  1  host read data valid, reads only
host_rdata  out  DATA_W  host read data
fill_start  in  1  pulse: begin frame fill
fill_color  in  DATA_W  fill value, sampled on fill_start
fill_busy  out  1  fill in progress
fill_done  out  1  one-cycle pulse when the last fill write has issued
mem_address  out  ADDR_W  to memory s1 address
mem_chipselect  out  1  to memory chipselect
mem_write  out  1  to memory write
mem_writedata  out  DATA_W  to memory writedata
mem_clken  out  1  to memory clken, constant 1
mem_readdata  in  DATA_W  from memory readdata

Behaviour:
- Reset (async, rst_n=0): all outputs 0 except mem_clken=1. FSM returns to IDLE. Starvation counter and fill address clear. In-flight read tags are discarded, so no rvalid pulses occur after reset.
- Secondary side: the fill engine when fill_busy=1, otherwise the host. host_gnt is 0 for the whole of a fill.
- Grant is combinational in the request cycle and one-hot. Priority: VGA over secondary, unless starve_cnt==MAX_WAIT, in which case the secondary is granted and vga_gnt=0.
- starve_cnt increments each cycle the secondary requests and is denied. It clears on a secondary grant and saturates at MAX_WAIT.
- Memory signals are registered: the granted access appears on mem_* the cycle after the grant. mem_chipselect=0 in idle cycles.
- Read return: a tag shift register of depth READ_LATENCY+1 records the owner (VGA or host). rvalid pulses exactly READ_LATENCY+1 cycles after the grant cycle, with rdata=mem_readdata. rdata holds its last value otherwise.
- Host address >= PIXELS: the request is granted but not issued (chipselect=0). A write is dropped. A read still returns rvalid at the normal latency with rdata=0x00.
- Fill FSM, states IDLE -> FILL -> DONE -> IDLE:
  - IDLE: fill_start latches fill_color, sets fill_addr=0, and moves to FILL.
  - FILL: each secondary grant issues a write of the colour to fill_addr, then fill_addr++. The grant at fill_addr==PIXELS-1 moves to DONE.
  - DONE: fill_done=1 for one cycle, then IDLE.
  - fill_busy=1 in FILL and DONE. fill_start outside IDLE is ignored.
- Simultaneous VGA and fill requests: the priority/starvation rules apply unchanged. A fill of 307200 pixels therefore completes under continuous VGA load.
- Memory write and read are never issued in the same cycle.

Decomposition:
- Package bg_mem_pkg: ADDR_W, DATA_W, PIXELS, owner enum (OWN_NONE, OWN_VGA, OWN_HOST), fill state enum.
- Sub-module bg_rd_return: tag shift register plus rvalid/rdata steering, parameterised by READ_LATENCY.
- Arbiter, starvation counter and fill FSM stay in the top module.

Test Plan:
- Reset mid-read: VGA read of 0x00010 granted, then rst_n pulsed low 1 cycle later -> no vga_rvalid, all outputs 0, mem_clken=1.
- VGA only, READ_LATENCY=1, preload addr 0x00005=0x3C: vga_req at cycle N -> vga_gnt at N, mem_chipselect at N+1, vga_rvalid with 0x3C at N+2.
- Host write then read: write 0xA5 to 0x4AFFF, then read it -> host_rvalid with 0xA5 two cycles after the read grant. Write to 307200 -> no mem_chipselect; a read there returns 0x00.
- Starvation: vga_req held high with host_req high, MAX_WAIT=8 -> host_gnt on the 9th cycle, vga_gnt=0 that cycle, then VGA resumes.
- Fill under continuous VGA load, fill_color=0x1F -> fill_done after exactly 307200 writes. Memory spot checks at 0, 153600 and 307199 all read 0x1F. host_gnt stays 0 while fill_busy=1.
- fill_start reasserted with colour 0x00 during FILL -> ignored; the final memory contents are all 0x1F.
